// File: rtl/mach_v_hazard_defs.sv
// Shared constants for the Mach-V hazard unit: opcode decode values, forward-select
// encodings and source-register activity helpers.
package mach_v_hazard_defs;

  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] STORE = 7'b0100011;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  function automatic logic rs1_active(input logic [6:0] opc);
    return !(opc == JAL || opc == LUI || opc == AUIPC);
  endfunction

  function automatic logic rs2_active(input logic [6:0] opc);
    return rs1_active(opc) &&
           !(opc == LOAD || opc == OPIMM || opc == JALR || opc == STORE);
  endfunction

endpackage

// File: rtl/hazard_mc_fifo.sv
// In-order tag FIFO for outstanding multi-cycle ops: destination tags, occupancy
// count, full/empty flags and the head tag (forced to 0 while empty).
module hazard_mc_fifo #(
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_tag_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_q <= count_q + CW'(1);
      else if (pop_i && !push_i) count_q <= count_q - CW'(1);
    end
  end

  // NOTE: tag storage is deliberately left unreset; empty_o masks the head,
  // and a reset-free array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_tag_i;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/hazard_scoreboard.sv
// Mach-V hazard unit: M/W forwarding, load-use stall, mispredict flush and a
// multi-cycle scoreboard. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_scoreboard
  import mach_v_hazard_defs::*;
#(
  parameter int REG_AW      = 5,
  parameter int MC_DEPTH    = 2,
  parameter int LOAD_STAGES = 1
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rdD,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rs2M,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic [6:0]        OpcodeD,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemWriteM,
  input  logic              MemtoRegE,
  input  logic              MemtoRegW,
  input  logic              IsMCycleD,
  input  logic              IsMCycleE,
  input  logic              McDone,
  input  logic              BranchMispredictM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardM,
  output logic              Forward1D,
  output logic              Forward2D,
  output logic [REG_AW-1:0] McWbRd,
  output logic              McFull,
  output logic              McEmpty,
  output logic              lwStall,
  output logic              sbStall,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       PerfLwStall,
  output logic [31:0]       PerfSbStall,
  output logic [31:0]       PerfFlush
`endif
);

  localparam int NREG = 2 ** REG_AW;
  localparam int CW   = $clog2(MC_DEPTH + 1);

  logic rs1_act, rs2_act, m_wr, w_wr;
  assign rs1_act = rs1_active(OpcodeD);
  assign rs2_act = rs2_active(OpcodeD);
  assign m_wr    = RegWriteM && (rdM != '0);
  assign w_wr    = RegWriteW && (rdW != '0);

  assign ForwardAE = (m_wr && rdM == rs1E) ? FWD_M : (w_wr && rdW == rs1E) ? FWD_W : FWD_RF;
  assign ForwardBE = (m_wr && rdM == rs2E) ? FWD_M : (w_wr && rdW == rs2E) ? FWD_W : FWD_RF;
  assign ForwardM  = MemWriteM && MemtoRegW && (rs2M == rdW) && (rdW != '0);
  assign Forward1D = w_wr && (rdW == rs1D);
  assign Forward2D = w_wr && (rdW == rs2D);

  logic lw_e_hit, trk_hit;
  assign lw_e_hit = MemtoRegE && (rdE != '0) &&
                    ((rs1_act && rs1D == rdE) || (rs2_act && rs2D == rdE));

  // Deeper load pipes: remember loads that left E but cannot be forwarded yet.
  if (LOAD_STAGES > 1) begin : g_ld_trk
    logic              ld_v_q  [LOAD_STAGES-1];
    logic [REG_AW-1:0] ld_rd_q [LOAD_STAGES-1];

    always_ff @(posedge CLK) begin
      if (!RESETn) begin
        for (int i = 0; i < LOAD_STAGES - 1; i++) begin
          ld_v_q[i]  <= 1'b0;
          ld_rd_q[i] <= '0;
        end
      end else begin
        ld_v_q[0]  <= MemtoRegE && (rdE != '0) && !BranchMispredictM;
        ld_rd_q[0] <= rdE;
        for (int i = 1; i < LOAD_STAGES - 1; i++) begin
          ld_v_q[i]  <= ld_v_q[i-1];
          ld_rd_q[i] <= ld_rd_q[i-1];
        end
      end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
      trk_hit = 1'b0;
      for (int i = 0; i < LOAD_STAGES - 1; i++) begin
        if (ld_v_q[i] && ((rs1_act && rs1D == ld_rd_q[i]) || (rs2_act && rs2D == ld_rd_q[i])))
          trk_hit = 1'b1;
      end
    end
  end else begin : g_no_ld_trk
    assign trk_hit = 1'b0;
  end

  assign lwStall = lw_e_hit || trk_hit;

  logic          mc_issue, mc_pop;
  logic [CW-1:0] mc_count;
  logic [NREG-1:0] pend_q, pend_d;

  // Issue is not blocked by the D-side stall: the op in E is already committed.
  assign mc_issue = IsMCycleE && !BranchMispredictM && !McFull;
  assign mc_pop   = McDone && !McEmpty;

  hazard_mc_fifo #(.AW(REG_AW), .DEPTH(MC_DEPTH)) u_mc_fifo (
    .clk       (CLK),
    .rst_n     (RESETn),
    .push_i    (mc_issue),
    .push_tag_i(rdE),
    .pop_i     (mc_pop),
    .head_o    (McWbRd),
    .count_o   (mc_count),
    .full_o    (McFull),
    .empty_o   (McEmpty)
  );

  // Set after clear so a register retired and reissued in one cycle stays pending.
  always_comb begin
    pend_d = pend_q;
    if (mc_pop)   pend_d[McWbRd] = 1'b0;
    if (mc_issue) pend_d[rdE]    = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign sbStall = (rs1_act && pend_q[rs1D]) || (rs2_act && pend_q[rs2D]) ||
                   ((rdD != '0) && pend_q[rdD]) ||
                   (IsMCycleD && (McFull || (mc_count == CW'(MC_DEPTH - 1) && IsMCycleE)));

  assign StallF = (lwStall || sbStall) && !BranchMispredictM;
  assign StallD = StallF;
  assign FlushE = lwStall || sbStall || BranchMispredictM;
  assign FlushD = BranchMispredictM;
  assign FlushM = BranchMispredictM;

  a_done_when_empty: assert property (@(posedge CLK) disable iff (!RESETn) !(McDone && McEmpty));

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lw_q, perf_sb_q, perf_fl_q;
  logic        bm_q;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      perf_lw_q <= '0;
      perf_sb_q <= '0;
      perf_fl_q <= '0;
      bm_q      <= 1'b0;
    end else begin
      if (lwStall && perf_lw_q != '1) perf_lw_q <= perf_lw_q + 32'd1;
      if (sbStall && !lwStall && perf_sb_q != '1) perf_sb_q <= perf_sb_q + 32'd1;
      if (BranchMispredictM && !bm_q && perf_fl_q != '1) perf_fl_q <= perf_fl_q + 32'd1;
      bm_q <= BranchMispredictM;
    end
  end

  assign PerfLwStall = perf_lw_q;
  assign PerfSbStall = perf_sb_q;
  assign PerfFlush   = perf_fl_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed vectors queue their expected
// outputs; a negedge monitor pops and compares.
module tb_hazard_scoreboard;
  import mach_v_hazard_defs::*;

  localparam int AW = 5;

  // Expected control bits: {lw, sb, StallF, StallD, FlushD, FlushE, FlushM}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LW    = 7'b1011010;
  localparam logic [6:0] C_SB    = 7'b0111010;
  localparam logic [6:0] C_BR    = 7'b0000111;
  localparam logic [6:0] C_SB_BR = 7'b0100111;
  // Expected FIFO status: {McFull, McEmpty}
  localparam logic [1:0] S_EMPTY = 2'b01;
  localparam logic [1:0] S_MID   = 2'b00;
  localparam logic [1:0] S_FULL  = 2'b10;
  localparam logic [6:0] F_NONE  = 7'b0000000;
  localparam logic [6:0] OPC_OP  = 7'b0110011;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic [AW-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rs2M, rdM, rdW;
  logic [6:0]    OpcodeD;
  logic          RegWriteM, RegWriteW, MemWriteM, MemtoRegE, MemtoRegW;
  logic          IsMCycleD, IsMCycleE, McDone, BranchMispredictM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ForwardM, Forward1D, Forward2D;
  logic [AW-1:0] McWbRd;
  logic          McFull, McEmpty, lwStall, sbStall, StallF, StallD, FlushD, FlushE, FlushM;

  always #5 CLK = ~CLK;

  hazard_scoreboard #(.REG_AW(AW), .MC_DEPTH(2), .LOAD_STAGES(1)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .rs2M(rs2M), .rdM(rdM), .rdW(rdW), .OpcodeD(OpcodeD),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemWriteM(MemWriteM),
    .MemtoRegE(MemtoRegE), .MemtoRegW(MemtoRegW),
    .IsMCycleD(IsMCycleD), .IsMCycleE(IsMCycleE), .McDone(McDone),
    .BranchMispredictM(BranchMispredictM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardM(ForwardM),
    .Forward1D(Forward1D), .Forward2D(Forward2D), .McWbRd(McWbRd),
    .McFull(McFull), .McEmpty(McEmpty), .lwStall(lwStall), .sbStall(sbStall),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM)
  );

  int          checks = 0;
  int          errors = 0;
  string       name_q[$];
  logic [20:0] exp_q[$];
  logic [20:0] act;

  assign act = {lwStall, sbStall, StallF, StallD, FlushD, FlushE, FlushM,
                McFull, McEmpty, McWbRd,
                ForwardAE, ForwardBE, ForwardM, Forward1D, Forward2D};

  task automatic check(input string nm, input logic [20:0] a, input logic [20:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got ctl=%b st=%b wb=%0d fwd=%b, want ctl=%b st=%b wb=%0d fwd=%b",
               nm, a[20:14], a[13:12], a[11:7], a[6:0], e[20:14], e[13:12], e[11:7], e[6:0]);
    end
  endtask

  always @(negedge CLK) begin
    while (exp_q.size() > 0) check(name_q.pop_front(), act, exp_q.pop_front());
  end

  task automatic nop();
    rs1D = '0; rs2D = '0; rdD = '0; rs1E = '0; rs2E = '0; rdE = '0;
    rs2M = '0; rdM = '0; rdW = '0; OpcodeD = OPC_OP;
    RegWriteM = 0; RegWriteW = 0; MemWriteM = 0; MemtoRegE = 0; MemtoRegW = 0;
    IsMCycleD = 0; IsMCycleE = 0; McDone = 0; BranchMispredictM = 0;
  endtask

  task automatic d_op(input int rd, input int r1, input int r2);
    rdD = AW'(rd); rs1D = AW'(r1); rs2D = AW'(r2);
  endtask

  task automatic e_mul(input int rd);
    IsMCycleE = 1; rdE = AW'(rd);
  endtask

  // Queue the expectation for the inputs now applied, then advance one cycle.
  task automatic vec(input string nm, input logic [6:0] ctl, input logic [1:0] st,
                     input logic [4:0] wb, input logic [6:0] fwd);
    name_q.push_back(nm);
    exp_q.push_back({ctl, st, wb, fwd});
    @(posedge CLK);
    #1;
    nop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESETn = 0;
    nop();
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1;

    vec("reset_state", C_NONE, S_EMPTY, 0, F_NONE);

    // Forwarding: M priority, W path, mem-mem copy, x0 never forwarded
    rs1E = 3; rs2E = 3; rdM = 3; RegWriteM = 1; rdW = 3; RegWriteW = 1; rs1D = 3;
    vec("fwd_m_priority", C_NONE, S_EMPTY, 0, 7'b1010010);
    rs1E = 3; rs2E = 5; rdM = 3; rdW = 5; RegWriteW = 1; rs2D = 5;
    MemWriteM = 1; MemtoRegW = 1; rs2M = 5;
    vec("fwd_w_and_mem", C_NONE, S_EMPTY, 0, 7'b0001101);
    RegWriteM = 1; RegWriteW = 1; MemWriteM = 1; MemtoRegW = 1;
    vec("fwd_x0", C_NONE, S_EMPTY, 0, F_NONE);

    // Load-use
    MemtoRegE = 1; rdE = 5; d_op(6, 5, 1);
    vec("lw_use_rs1", C_LW, S_EMPTY, 0, F_NONE);
    d_op(6, 5, 1);
    vec("lw_released", C_NONE, S_EMPTY, 0, F_NONE);
    MemtoRegE = 1; rdE = 5; OpcodeD = LUI; d_op(5, 5, 5);
    vec("lw_lui_no_stall", C_NONE, S_EMPTY, 0, F_NONE);
    MemtoRegE = 1; rdE = 5; d_op(6, 1, 5);
    vec("lw_use_rs2", C_LW, S_EMPTY, 0, F_NONE);
    MemtoRegE = 1; rdE = 0;
    vec("lw_x0", C_NONE, S_EMPTY, 0, F_NONE);

    // Non-blocking mul: independent flow, RAW stall until retire
    e_mul(7); d_op(8, 1, 2);
    vec("mul_issue", C_NONE, S_EMPTY, 0, F_NONE);
    d_op(10, 3, 4);
    vec("indep_flows", C_NONE, S_MID, 7, F_NONE);
    d_op(9, 7, 1);
    vec("raw_stall", C_SB, S_MID, 7, F_NONE);
    d_op(9, 7, 1); McDone = 1;
    vec("raw_done_cycle", C_SB, S_MID, 7, F_NONE);
    d_op(9, 7, 1);
    vec("raw_release", C_NONE, S_EMPTY, 0, F_NONE);

    // FIFO depth limit and WAW
    e_mul(11); d_op(1, 2, 3);
    vec("mul_a", C_NONE, S_EMPTY, 0, F_NONE);
    e_mul(12); IsMCycleD = 1; d_op(13, 1, 2);
    vec("mul_b_near_full", C_SB, S_MID, 11, F_NONE);
    IsMCycleD = 1; d_op(13, 1, 2);
    vec("full_stall", C_SB, S_FULL, 11, F_NONE);
    d_op(12, 1, 2);
    vec("waw_stall", C_SB, S_FULL, 11, F_NONE);
    IsMCycleD = 1; d_op(13, 1, 2); McDone = 1;
    vec("full_done_cycle", C_SB, S_FULL, 11, F_NONE);
    IsMCycleD = 1; d_op(13, 1, 2);
    vec("full_released", C_NONE, S_MID, 12, F_NONE);

    // Same-cycle push and pop
    e_mul(10); McDone = 1; d_op(1, 2, 3);
    vec("push_pop", C_NONE, S_MID, 12, F_NONE);
    d_op(14, 10, 0);
    vec("pp_x10_pending", C_SB, S_MID, 10, F_NONE);
    d_op(15, 12, 0);
    vec("pp_x12_cleared", C_NONE, S_MID, 10, F_NONE);
    e_mul(10); McDone = 1; d_op(1, 2, 3);
    vec("set_wins_cycle", C_NONE, S_MID, 10, F_NONE);
    d_op(14, 10, 0);
    vec("set_wins_kept", C_SB, S_MID, 10, F_NONE);

    // Mispredict: op in E not pushed, older entries retained
    e_mul(13); BranchMispredictM = 1; d_op(1, 2, 3);
    vec("mispredict", C_BR, S_MID, 10, F_NONE);
    d_op(1, 13, 0);
    vec("mp_not_pushed", C_NONE, S_MID, 10, F_NONE);
    d_op(1, 10, 0);
    vec("mp_older_kept", C_SB, S_MID, 10, F_NONE);
    d_op(1, 10, 0); BranchMispredictM = 1;
    vec("mp_over_stall", C_SB_BR, S_MID, 10, F_NONE);

    // Synchronous reset mid-operation overrides issue and completion
    e_mul(16); d_op(1, 2, 3);
    vec("fill_two", C_NONE, S_MID, 10, F_NONE);
    d_op(1, 16, 0);
    vec("two_pending", C_SB, S_FULL, 10, F_NONE);
    RESETn = 0; d_op(1, 16, 0); e_mul(17); McDone = 1;
    vec("reset_cycle", C_SB, S_FULL, 10, F_NONE);
    RESETn = 1; IsMCycleD = 1; d_op(17, 16, 10);
    vec("post_reset", C_NONE, S_EMPTY, 0, F_NONE);

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
